clock_adjust_ctrl: RTL and testbench

Front-panel control stage sitting directly upstream of the clock/alarm up/down mod counters. Takes debounced, synchronised mode/up/down button levels and runs a mode FSM that selects which time field is being set. It generates single-cycle enable pulses and the up/down direction for the selected counter, with hold-to-auto-repeat and an idle timeout back to normal run. It also produces the run enable that gates normal timekeeping.

---
 rtl/clock_pkg.sv | 53 +++++
 rtl/hold_repeat_timer.sv | 64 ++++++
 rtl/clock_adjust_ctrl.sv | 121 ++++++++++++
 tb/tb_clock_adjust_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared state codes, field indices and helpers for clock adjust.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_CMIN  = 3'd1,
    SET_CHOUR = 3'd2,
    SET_AMIN  = 3'd3,
    SET_AHOUR = 3'd4
  } state_e;

  localparam int CMIN  = 0;
  localparam int CHOUR = 1;
  localparam int AMIN  = 2;
  localparam int AHOUR = 3;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  function automatic state_e next_mode(input state_e s);
    state_e n;
    case (s)
      RUN:       n = SET_CMIN;
      SET_CMIN:  n = SET_CHOUR;
      SET_CHOUR: n = SET_AMIN;
      SET_AMIN:  n = SET_AHOUR;
      default:   n = RUN;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] field_onehot(input state_e s);
    logic [3:0] v;
    v = 4'b0000;
    case (s)
      SET_CMIN:  v[CMIN]  = 1'b1;
      SET_CHOUR: v[CHOUR] = 1'b1;
      SET_AMIN:  v[AMIN]  = 1'b1;
      SET_AHOUR: v[AHOUR] = 1'b1;
      default:   v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hold_repeat_timer.sv
// ============================================================================
// Module   : hold_repeat_timer
// Purpose  : Hold-to-auto-repeat timer; fires once after HOLD_TICKS, then
//            every REPEAT_TICKS ticks while level stays high.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hold_repeat_timer #(
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic tick_en,
  output logic fire
);

  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW:0] HOLD_LIM = (CW + 1)'(HOLD_TICKS);
  localparam logic [CW:0] REP_LIM  = (CW + 1)'(REPEAT_TICKS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          repeat_q, repeat_d;
  logic [CW:0]   cnt_inc;
  logic [CW:0]   limit;

  assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
  assign limit   = repeat_q ? REP_LIM : HOLD_LIM;

  // The count restarts at each fire, so it never exceeds its limit.
  always_comb begin
    cnt_d    = cnt_q;
    repeat_d = repeat_q;
    fire     = 1'b0;
    if (!level) begin
      cnt_d    = '0;
      repeat_d = 1'b0;
    end else if (tick_en) begin
      if (cnt_inc >= limit) begin
        fire     = 1'b1;
        cnt_d    = '0;
        repeat_d = 1'b1;
      end else begin
        cnt_d = cnt_inc[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      repeat_q <= repeat_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_adjust_ctrl.sv
// ============================================================================
// Module   : clock_adjust_ctrl
// Purpose  : Front-panel mode FSM producing adjust pulses, direction and run
//            enable for the clock/alarm counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_adjust_ctrl
  import clock_pkg::*;
#(
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter int IDLE_TICKS   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       run_en,
  output logic [3:0] adj_en,
  output logic       up_down,
  output logic [2:0] mode
);

  localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
  localparam logic [IDLE_W:0] IDLE_LIM = (IDLE_W + 1)'(IDLE_TICKS);

  state_e            state_q, state_d;
  logic              mode_prev_q, up_prev_q, down_prev_q;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              run_en_q, run_en_d;
  logic [3:0]        adj_en_q, adj_en_d;
  logic              up_down_q, up_down_d;

  logic              mode_edge, up_edge, down_edge;
  logic              in_set, any_btn, rep_level, rep_fire;
  logic              pulse, pulse_dir;
  logic [IDLE_W:0]   idle_inc;

  assign mode_edge = btn_mode & ~mode_prev_q;
  assign up_edge   = btn_up & ~up_prev_q;
  assign down_edge = btn_down & ~down_prev_q;
  assign in_set    = (state_q != RUN);
  assign any_btn   = btn_mode | btn_up | btn_down;
  assign idle_inc  = {1'b0, idle_q} + (IDLE_W + 1)'(1);

  // Repeat only runs with exactly one direction held; a mode edge clears it.
  assign rep_level = in_set & ~mode_edge & (btn_up ^ btn_down);

  hold_repeat_timer #(
    .HOLD_TICKS   (HOLD_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) u_hold_repeat (
    .clk     (clk),
    .rst     (rst),
    .level   (rep_level),
    .tick_en (tick_en),
    .fire    (rep_fire)
  );

  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    pulse     = 1'b0;
    pulse_dir = up_down_q;
    if (mode_edge) begin
      state_d = next_mode(state_q);
    end else if (in_set) begin
      if (any_btn) begin
        idle_d = '0;
      end else if (tick_en) begin
        if (idle_inc >= IDLE_LIM) state_d = RUN;
        else                      idle_d  = idle_inc[IDLE_W-1:0];
      end
      if (up_edge ^ down_edge) begin
        pulse     = 1'b1;
        pulse_dir = down_edge ? DOWN : UP;
      end else if (rep_fire) begin
        pulse     = 1'b1;
        pulse_dir = btn_down ? DOWN : UP;
      end
    end
    if (state_d != state_q) idle_d = '0;
    run_en_d  = (state_d == RUN);
    adj_en_d  = pulse ? field_onehot(state_q) : 4'b0000;
    up_down_d = pulse_dir;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      idle_q      <= '0;
      run_en_q    <= 1'b1;
      adj_en_q    <= 4'b0000;
      up_down_q   <= UP;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= btn_mode;
      up_prev_q   <= btn_up;
      down_prev_q <= btn_down;
      idle_q      <= idle_d;
      run_en_q    <= run_en_d;
      adj_en_q    <= adj_en_d;
      up_down_q   <= up_down_d;
    end
  end

  assign run_en  = run_en_q;
  assign adj_en  = adj_en_q;
  assign up_down = up_down_q;
  assign mode    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_adjust_ctrl.sv
// ============================================================================
// Module   : tb_clock_adjust_ctrl
// Purpose  : Directed self-checking bench for clock_adjust_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clock_adjust_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic       btn_mode, btn_up, btn_down;
  logic       run_en;
  logic [3:0] adj_en;
  logic       up_down;
  logic [2:0] mode;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int base;
  logic [9:0] mask;

  clock_adjust_ctrl #(
    .HOLD_TICKS   (4),
    .REPEAT_TICKS (2),
    .IDLE_TICKS   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_en  (tick_en),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .run_en   (run_en),
    .adj_en   (adj_en),
    .up_down  (up_down),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (adj_en != 4'd0) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    cyc();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b0; tick_en = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (2) cyc();

    // Reset held while buttons toggle
    for (int i = 0; i < 4; i++) begin
      btn_mode = i[0]; btn_up = ~i[0]; btn_down = i[1]; tick_en = 1'b1;
      cyc();
      check_val("rst_run_en", 32'(run_en), 32'd1);
      check_val("rst_mode",   32'(mode),   32'd0);
      check_val("rst_adj_en", 32'(adj_en), 32'd0);
    end
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; tick_en = 1'b0;
    cyc();
    rst = 1'b1;
    cyc(); cyc();
    check_val("post_rst_mode", 32'(mode), 32'd0);

    press_mode();
    check_val("mode1", 32'(mode), 32'd1);
    check_val("mode1_run_en", 32'(run_en), 32'd0);
    press_mode();
    check_val("mode2", 32'(mode), 32'd2);

    // Single down press in SET_CHOUR
    base = pulse_cnt;
    btn_down = 1'b1;
    cyc();
    check_val("down_adj", 32'(adj_en), 32'h2);
    check_val("down_dir", 32'(up_down), 32'd1);
    btn_down = 1'b0;
    cyc();
    check_val("down_adj_end", 32'(adj_en), 32'h0);
    check_val("down_dir_hold", 32'(up_down), 32'd1);
    cyc();
    check_val("down_pulses", 32'(pulse_cnt - base), 32'd1);

    press_mode();
    check_val("mode3", 32'(mode), 32'd3);
    check_val("mode3_run_en", 32'(run_en), 32'd0);

    // Idle timeout, restarted by a press after tick 4
    repeat (4) tick();
    check_val("idle_t4_mode", 32'(mode), 32'd3);
    btn_up = 1'b1;
    cyc();
    check_val("amin_up_adj", 32'(adj_en), 32'h4);
    check_val("amin_up_dir", 32'(up_down), 32'd0);
    btn_up = 1'b0;
    cyc();
    repeat (4) tick();
    check_val("idle_restart_mode", 32'(mode), 32'd3);
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    check_val("idle_timeout_mode", 32'(mode), 32'd0);
    check_val("idle_timeout_run_en", 32'(run_en), 32'd1);
    cyc();

    // Up/down ignored in RUN
    base = pulse_cnt;
    btn_up = 1'b1;
    cyc();
    check_val("run_up_adj", 32'(adj_en), 32'h0);
    btn_up = 1'b0; btn_down = 1'b1;
    cyc();
    check_val("run_down_adj", 32'(adj_en), 32'h0);
    btn_down = 1'b0;
    cyc();
    check_val("run_pulses", 32'(pulse_cnt - base), 32'd0);

    // Auto-repeat in SET_CMIN
    press_mode();
    check_val("rep_mode", 32'(mode), 32'd1);
    base = pulse_cnt;
    mask = '0;
    btn_up = 1'b1;
    cyc();
    check_val("rep_edge_adj", 32'(adj_en), 32'h1);
    for (int k = 1; k <= 10; k++) begin
      tick_en = 1'b1;
      cyc();
      if (adj_en[0]) mask[k-1] = 1'b1;
      tick_en = 1'b0;
      cyc();
    end
    btn_up = 1'b0;
    cyc();
    check_val("rep_tick_mask", 32'(mask), 32'h2A8);
    check_val("rep_pulses", 32'(pulse_cnt - base), 32'd5);
    check_val("rep_dir", 32'(up_down), 32'd0);

    // Simultaneous events
    base = pulse_cnt;
    btn_up = 1'b1; btn_down = 1'b1;
    cyc();
    check_val("both_adj", 32'(adj_en), 32'h0);
    btn_up = 1'b0; btn_down = 1'b0;
    cyc();
    check_val("both_mode", 32'(mode), 32'd1);
    btn_mode = 1'b1; btn_up = 1'b1;
    cyc();
    check_val("mode_up_mode", 32'(mode), 32'd2);
    check_val("mode_up_adj", 32'(adj_en), 32'h0);
    btn_mode = 1'b0; btn_up = 1'b0;
    cyc(); cyc();
    check_val("simul_pulses", 32'(pulse_cnt - base), 32'd0);

    // Reset during auto-repeat
    btn_down = 1'b1;
    cyc();
    check_val("rr_edge_adj", 32'(adj_en), 32'h2);
    check_val("rr_edge_dir", 32'(up_down), 32'd1);
    repeat (3) tick();
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    check_val("rr_fire_adj", 32'(adj_en), 32'h2);
    #2 rst = 1'b0;
    #1;
    check_val("rr_async_adj", 32'(adj_en), 32'h0);
    check_val("rr_async_mode", 32'(mode), 32'd0);
    check_val("rr_async_run_en", 32'(run_en), 32'd1);
    check_val("rr_async_dir", 32'(up_down), 32'd0);
    cyc();
    btn_down = 1'b0; btn_up = 1'b1;
    cyc();
    rst = 1'b1;
    base = pulse_cnt;
    repeat (6) tick();
    check_val("run_hold_pulses", 32'(pulse_cnt - base), 32'd0);
    btn_mode = 1'b1;
    cyc();
    check_val("reenter_mode", 32'(mode), 32'd1);
    check_val("reenter_adj", 32'(adj_en), 32'h0);
    btn_mode = 1'b0;
    repeat (3) tick();
    check_val("reenter_hold3", 32'(pulse_cnt - base), 32'd0);
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    check_val("reenter_fire_adj", 32'(adj_en), 32'h1);
    check_val("reenter_fire_dir", 32'(up_down), 32'd0);
    cyc();
    btn_up = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
